cond_decrement_stream: RTL and testbench
========================================

Name: cond_decrement_stream

Overview:
- Streaming inverse of the conditional-increment map f(a) = (a > THRESHOLD) ? a : a+1.
- Recovers a preimage for each input word and flags the two cases f cannot invert uniquely: b = THRESHOLD+1 has two preimages, and b = 0 has none.
- Two-stage valid/ready pipeline with full throughput and backpressure.
- Sits downstream of conditional-increment producers. Used to check round-trips and to decode results in the test designs.

Parameters:
- WIDTH, 32, data word width.
- THRESHOLD, 4096, compare constant of the forward map; must be < 2^WIDTH - 1.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept input this cycle
- in_data  input  WIDTH  encoded word b
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  recovered preimage a
- out_ambig  output  1  b == THRESHOLD+1; two preimages exist
- out_invalid  output  1  b == 0; no preimage
- ambig_count  output  CNT_W  number of ambiguous results delivered
- invalid_count  output  CNT_W  number of invalid results delivered

Behaviour:
- Decode rule, all arithmetic unsigned WIDTH-bit:
  - b > THRESHOLD+1 -> a = b, flags 0.
  - b == THRESHOLD+1 -> a = THRESHOLD+1 (pass-through preimage chosen), out_ambig=1.
  - 1 <= b <= THRESHOLD -> a = b-1, flags 0.
  - b == 0 -> a = 0 (no subtraction, no wrap), out_invalid=1.
  - out_ambig and out_invalid are never both 1.
- Stage 1 (s1):
  - Registers b, plus a 2-bit class from comparisons against THRESHOLD+1 and 0.
  - Class values: PASS, AMBIG, DEC, INVALID.
  - The compare logic sits in its own submodule so it can be tagged private.
- Stage 2 (s2):
  - Computes a from the s1 class and b.
  - Registers out_data and the flags; holds out_valid.
- Handshake:
  - Transfer on in_valid && in_ready, and on out_valid && out_ready.
  - s2 loads when s2 is empty or out_ready=1.
  - s1 advances into s2 when s2 loads.
  - in_ready = !s1_valid || s2_loads. Combinational from out_ready; no other combinational in->out path.
  - Latency: 2 cycles from input handshake to out_valid when unstalled. Throughput 1 word/cycle.
  - While out_valid && !out_ready: out_data, out_ambig and out_invalid hold stable.
  - in_data is ignored when in_valid=0. in_ready may be 1 regardless of in_valid.
- Counters:
  - ambig_count increments on each output handshake with out_ambig=1.
  - invalid_count increments likewise on out_invalid=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset:
  - out_valid=0, out_data=0, out_ambig=0, out_invalid=0, counters=0.
  - Internal valids are cleared. in_ready=1 in the first cycle after reset deasserts.
  - Reset mid-stream discards all in-flight words. No partial output appears after reset.
- Boundaries:
  - b = 2^WIDTH-1 decodes to PASS, a = b.
  - b = THRESHOLD decodes to a = THRESHOLD-1.
  - b = 1 decodes to a = 0.
  - Simultaneous input handshake and output handshake with both stages full: s2 takes s1, s1 takes the new word, nothing is dropped or duplicated.

Test Plan:
- Reset, then stream b = 5, 4096, 4097, 4098, 0, 0xFFFFFFFF with out_ready=1. Required outputs on cycles 2..7:
  - a = 4, 4095, 4097, 4098, 0, 0xFFFFFFFF.
  - out_ambig only on the third word; out_invalid only on the fifth.
  - ambig_count=1, invalid_count=1.
- Round-trip: random a through the forward map, then this block, 10k words. Required:
  - out_data == a whenever out_ambig=0 and out_invalid=0.
  - out_ambig=1 exactly when a is 4096 or 4097.
  - out_invalid never 1.
- Backpressure: hold out_ready=0 for 5 cycles with continuous in_valid. Required:
  - in_ready drops after exactly 2 words are accepted.
  - out_data stays stable.
  - On release, words emerge in order with no loss or duplication.
- Random in_valid/out_ready toggling at 50% each, 5k words. Required: the output sequence equals the reference-model sequence in order.
- Saturation: set CNT_W=4 and send 20 words of b = 4097. Required: ambig_count stops at 15 and stays there.
- Assert rst for 1 cycle with both stages full. Required:
  - Next cycle out_valid=0, counters=0, in_ready=1.
  - The first new word appears 2 cycles after its handshake.

Source files
------------

// File: rtl/cond_decrement_stream.sv
// Streaming inverse of the conditional-increment map f(a) = (a > THRESHOLD) ? a : a+1.
// Two-stage valid/ready pipeline that flags ambiguous (THRESHOLD+1) and invalid (0) words.
package cond_decrement_stream_pkg;
    typedef enum logic [1:0] {
        CLS_PASS    = 2'd0,
        CLS_AMBIG   = 2'd1,
        CLS_DEC     = 2'd2,
        CLS_INVALID = 2'd3
    } cls_e;
endpackage

module cond_decrement_classify
    import cond_decrement_stream_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned THRESHOLD = 4096
) (
    input  logic [WIDTH-1:0] b_i,
    output cls_e             cls_o
);
    localparam logic [WIDTH-1:0] AMBIG_B = WIDTH'(THRESHOLD) + WIDTH'(1);

    always_comb begin
        cls_o = CLS_DEC;
        if (b_i == '0) begin
            cls_o = CLS_INVALID;
        end else if (b_i == AMBIG_B) begin
            cls_o = CLS_AMBIG;
        end else if (b_i > AMBIG_B) begin
            cls_o = CLS_PASS;
        end
    end
endmodule

module cond_decrement_stream
    import cond_decrement_stream_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned THRESHOLD = 4096,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ambig,
    output logic             out_invalid,
    output logic [CNT_W-1:0] ambig_count,
    output logic [CNT_W-1:0] invalid_count
);
    cls_e             cls_w;
    cls_e             s1_cls_q, s1_cls_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ambig_q, out_ambig_d;
    logic             out_invalid_q, out_invalid_d;
    logic [CNT_W-1:0] ambig_cnt_q, ambig_cnt_d;
    logic [CNT_W-1:0] invalid_cnt_q, invalid_cnt_d;

    logic             s2_load;
    logic             out_xfer;
    logic [WIDTH-1:0] a_w;
    logic             amb_w;
    logic             inv_w;

    cond_decrement_classify #(
        .WIDTH     (WIDTH),
        .THRESHOLD (THRESHOLD)
    ) u_classify (
        .b_i   (in_data),
        .cls_o (cls_w)
    );

    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        a_w   = s1_data_q;
        amb_w = 1'b0;
        inv_w = 1'b0;
        case (s1_cls_q)
            CLS_PASS:    a_w = s1_data_q;
            CLS_AMBIG:   amb_w = 1'b1;
            CLS_DEC:     a_w = s1_data_q - WIDTH'(1);
            CLS_INVALID: begin
                a_w   = '0;
                inv_w = 1'b1;
            end
        endcase
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_data_d     = s1_data_q;
        s1_cls_d      = s1_cls_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_ambig_d   = out_ambig_q;
        out_invalid_d = out_invalid_q;
        ambig_cnt_d   = ambig_cnt_q;
        invalid_cnt_d = invalid_cnt_q;

        // s1 refills in the same cycle it hands its word to s2
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_cls_d  = cls_w;
            end
        end

        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d    = a_w;
                out_ambig_d   = amb_w;
                out_invalid_d = inv_w;
            end
        end

        if (out_xfer && out_ambig_q && (ambig_cnt_q != '1)) begin
            ambig_cnt_d = ambig_cnt_q + CNT_W'(1);
        end
        if (out_xfer && out_invalid_q && (invalid_cnt_q != '1)) begin
            invalid_cnt_d = invalid_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '0;
            s1_cls_q      <= CLS_PASS;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_ambig_q   <= 1'b0;
            out_invalid_q <= 1'b0;
            ambig_cnt_q   <= '0;
            invalid_cnt_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_cls_q      <= s1_cls_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_ambig_q   <= out_ambig_d;
            out_invalid_q <= out_invalid_d;
            ambig_cnt_q   <= ambig_cnt_d;
            invalid_cnt_q <= invalid_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_ambig     = out_ambig_q;
    assign out_invalid   = out_invalid_q;
    assign ambig_count   = ambig_cnt_q;
    assign invalid_count = invalid_cnt_q;
endmodule

// File: tb/tb_cond_decrement_stream.sv
// Bench for cond_decrement_stream: directed vector table, backpressure, random streams,
// counter saturation on a narrow-counter instance, and mid-stream reset.
module tb_cond_decrement_stream;
    localparam int unsigned TH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_ambig, out_invalid;
    logic [31:0] in_data, out_data;
    logic [15:0] ambig_count, invalid_count;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_ambig, s_out_invalid;
    logic [31:0] s_in_data, s_out_data;
    logic [3:0]  s_ambig_count, s_invalid_count;

    always #5 clk = ~clk;

    cond_decrement_stream #(.WIDTH(32), .THRESHOLD(TH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ambig(out_ambig), .out_invalid(out_invalid),
        .ambig_count(ambig_count), .invalid_count(invalid_count)
    );

    cond_decrement_stream #(.WIDTH(32), .THRESHOLD(TH), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_ambig(s_out_ambig), .out_invalid(s_out_invalid),
        .ambig_count(s_ambig_count), .invalid_count(s_invalid_count)
    );

    typedef struct packed {
        logic [31:0] a;
        logic        amb;
        logic        inv;
    } exp_t;

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic        amb;
        logic        inv;
    } vec_t;

    int          n_vec = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [31:0] rt_q[$];
    bit          rt_mode = 1'b0;
    int          exp_amb_cnt = 0;
    int          exp_inv_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t decode(input logic [31:0] b);
        exp_t e;
        e.amb = 1'b0;
        e.inv = 1'b0;
        if (b == 32'd0) begin
            e.a   = 32'd0;
            e.inv = 1'b1;
        end else if (b <= TH) begin
            e.a = b - 32'd1;
        end else if (b == TH + 1) begin
            e.a   = b;
            e.amb = 1'b1;
        end else begin
            e.a = b;
        end
        return e;
    endfunction

    function automatic logic [31:0] fwd(input logic [31:0] a);
        return (a > TH) ? a : a + 32'd1;
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        case ($urandom_range(9))
            0:       w = 32'd0;
            1:       w = 32'd1;
            2:       w = TH - 1;
            3:       w = TH;
            4:       w = TH + 1;
            5:       w = TH + 2;
            6:       w = 32'hFFFF_FFFF;
            7:       w = $urandom_range(2 * TH);
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // Scoreboard: every accepted input queues its expected decode; every delivered output pops one.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] ra;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_out", {out_data, out_ambig, out_invalid}, e);
                    if (e.amb && exp_amb_cnt < 65535) exp_amb_cnt++;
                    if (e.inv && exp_inv_cnt < 65535) exp_inv_cnt++;
                end
                if (rt_mode) begin
                    if (rt_q.size() == 0) begin
                        chk("rt_missing", 64'd1, 64'd0);
                    end else begin
                        ra = rt_q.pop_front();
                        if (!out_ambig && !out_invalid) chk("rt_data", out_data, ra);
                        chk("rt_ambig", out_ambig, (ra == TH || ra == TH + 1));
                        chk("rt_invalid", out_invalid, 0);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(decode(in_data));
        end
    end

    task automatic run_stream(input int n, input int pv, input int pr, input bit rt);
        int          sent = 0;
        int          cyc = 0;
        bit          have = 1'b0;
        logic [31:0] a = 32'd0;
        logic [31:0] b = 32'd0;
        rt_mode = rt;
        while ((sent < n || exp_q.size() != 0) && cyc < n * 8 + 100) begin
            if (!have && sent < n) begin
                a    = gen_word();
                b    = rt ? fwd(a) : a;
                have = 1'b1;
            end
            in_valid  = have && ($urandom_range(99) < pv);
            in_data   = in_valid ? b : $urandom;
            out_ready = ($urandom_range(99) < pr);
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (rt) rt_q.push_back(a);
                have = 1'b0;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", sent, n);
        chk("stream_drained", exp_q.size(), 0);
        rt_mode = 1'b0;
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t        vecs[8];
        logic [31:0] bp_b[8];
        logic [33:0] held;
        bit          hold_set;
        int          acc;
        int          idx;
        int          sat_exp;

        vecs[0] = '{32'd5,          32'd4,          1'b0, 1'b0};
        vecs[1] = '{32'd4096,       32'd4095,       1'b0, 1'b0};
        vecs[2] = '{32'd4097,       32'd4097,       1'b1, 1'b0};
        vecs[3] = '{32'd4098,       32'd4098,       1'b0, 1'b0};
        vecs[4] = '{32'd0,          32'd0,          1'b0, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[6] = '{32'd1,          32'd0,          1'b0, 1'b0};
        vecs[7] = '{32'd4095,       32'd4094,       1'b0, 1'b0};
        bp_b = '{32'd10, 32'd4097, 32'd0, 32'd9000, 32'd4096, 32'd77, 32'd1, 32'd5000};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = 32'd4097; s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_flags", {out_ambig, out_invalid}, 0);
        chk("reset_counters", {ambig_count, invalid_count}, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed table: word c enters in cycle c, its result is visible in cycle c+2
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_data  = vecs[c].b;
            end else begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("dir_valid[%0d]", c - 2), out_valid, 1);
                chk($sformatf("dir_out[%0d]", c - 2), {out_data, out_ambig, out_invalid},
                    {vecs[c - 2].a, vecs[c - 2].amb, vecs[c - 2].inv});
            end else begin
                chk($sformatf("dir_latency[%0d]", c), out_valid, 0);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("dir_ambig_count", ambig_count, 1);
        chk("dir_invalid_count", invalid_count, 1);
        @(posedge clk); #1;

        // Backpressure: stall 5 cycles with a source that holds each word until accepted
        out_ready = 1'b0; acc = 0; idx = 0; hold_set = 1'b0; held = '0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = bp_b[idx];
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc++;
                idx++;
            end
            if (out_valid) begin
                if (!hold_set) begin
                    held     = {out_data, out_ambig, out_invalid};
                    hold_set = 1'b1;
                end else begin
                    chk("bp_hold", {out_data, out_ambig, out_invalid}, held);
                end
            end
            @(posedge clk); #1;
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && (idx < 8 || exp_q.size() != 0); c++) begin
            in_valid = (idx < 8);
            in_data  = (idx < 8) ? bp_b[idx] : 32'd0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", idx, 8);
        chk("bp_drained", exp_q.size(), 0);

        run_stream(10000, 100, 100, 1'b1);
        run_stream(5000, 50, 50, 1'b0);
        @(negedge clk);
        chk("rand_ambig_count", ambig_count, exp_amb_cnt);
        chk("rand_invalid_count", invalid_count, exp_inv_cnt);
        @(posedge clk); #1;

        // Saturation on the 4-bit-counter instance
        sat_exp = 0;
        for (int c = 0; c < 26; c++) begin
            s_in_valid = (c < 20);
            @(negedge clk);
            chk($sformatf("sat_count[%0d]", c), s_ambig_count, sat_exp);
            if (s_out_valid && s_out_ready && sat_exp < 15) sat_exp++;
            @(posedge clk); #1;
        end
        chk("sat_final", s_ambig_count, 15);
        chk("sat_invalid", s_invalid_count, 0);

        // Mid-stream reset with both stages full
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'd50 + c;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        exp_q.delete(); rt_q.delete();
        exp_amb_cnt = 0; exp_inv_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b1; in_data = 32'd4097; out_ready = 1'b1;
        @(negedge clk);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_counters", {ambig_count, invalid_count}, 0);
        chk("rst2_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_lat1", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst2_lat2", out_valid, 1);
        chk("rst2_word", {out_data, out_ambig, out_invalid}, {32'd4097, 1'b1, 1'b0});
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst2_ambig_count", ambig_count, 1);
        chk("rst2_no_extra", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
